// File: rtl/magnetron.sv
// Magnetron enable controller: synchronized pushbuttons and interlocks
// driving a two-state IDLE/COOK machine with a registered mag_on output.
module magnetron #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clearn,
    input  logic startn,
    input  logic stopn,
    input  logic door_closed,
    input  logic timer_done,
    output logic mag_on
);

    localparam logic [1:0] IDLE = 2'b01;
    localparam logic [1:0] COOK = 2'b10;

    logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
    logic [SYNC_STAGES-1:0] stop_sync_q, stop_sync_d;
    logic [SYNC_STAGES-1:0] door_sync_q, door_sync_d;
    logic [SYNC_STAGES-1:0] timer_sync_q, timer_sync_d;
    logic [SYNC_STAGES-1:0] valid_q, valid_d;
    logic                   edge_q, edge_d;
    logic                   arm_q, arm_d;
    logic                   start_evt_q, start_evt_d;
    logic                   mag_on_q, mag_on_d;
    logic [1:0]             state_q, state_d;

    logic start_s;
    logic stop_s;
    logic door_s;
    logic timer_s;
    logic stop_cond;
    logic start_fall;

    assign start_s   = start_sync_q[SYNC_STAGES-1];
    assign stop_s    = stop_sync_q[SYNC_STAGES-1];
    assign door_s    = door_sync_q[SYNC_STAGES-1];
    assign timer_s   = timer_sync_q[SYNC_STAGES-1];
    assign stop_cond = ~stop_s | ~door_s | timer_s;
    // Armed only once a real (post-reset) high on startn has been seen,
    // so a button held through reset cannot fake a falling edge.
    assign start_fall = arm_q & edge_q & ~start_s;

    always_comb begin
        start_sync_d = {start_sync_q[SYNC_STAGES-2:0], startn};
        stop_sync_d  = {stop_sync_q[SYNC_STAGES-2:0], stopn};
        door_sync_d  = {door_sync_q[SYNC_STAGES-2:0], door_closed};
        timer_sync_d = {timer_sync_q[SYNC_STAGES-2:0], timer_done};
        valid_d      = {valid_q[SYNC_STAGES-2:0], 1'b1};
        edge_d       = start_s;
        arm_d        = arm_q | (valid_q[SYNC_STAGES-1] & start_s);
        start_evt_d  = start_fall & ~stop_cond;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (stop_cond)
                    state_d = IDLE;
                else if (start_evt_q)
                    state_d = COOK;
                else
                    state_d = IDLE;
            end
            COOK:    state_d = stop_cond ? IDLE : COOK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mag_on_d = (state_d == COOK);
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            start_sync_q <= '1;
            stop_sync_q  <= '1;
            door_sync_q  <= '0;
            timer_sync_q <= '0;
            valid_q      <= '0;
            edge_q       <= 1'b1;
            arm_q        <= 1'b0;
            start_evt_q  <= 1'b0;
            state_q      <= IDLE;
            mag_on_q     <= 1'b0;
        end else begin
            start_sync_q <= start_sync_d;
            stop_sync_q  <= stop_sync_d;
            door_sync_q  <= door_sync_d;
            timer_sync_q <= timer_sync_d;
            valid_q      <= valid_d;
            edge_q       <= edge_d;
            arm_q        <= arm_d;
            start_evt_q  <= start_evt_d;
            state_q      <= state_d;
            mag_on_q     <= mag_on_d;
        end
    end

    assign mag_on = mag_on_q;

endmodule

// File: tb/tb_magnetron.sv
// Directed bench for magnetron: latency, stop priority, edge-only start,
// interlocks and asynchronous clear.
module tb_magnetron;

    logic clk = 1'b0;
    logic clearn;
    logic startn;
    logic stopn;
    logic door_closed;
    logic timer_done;
    logic mag_on;

    int total = 0;
    int bad = 0;

    magnetron #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .clearn     (clearn),
        .startn     (startn),
        .stopn      (stopn),
        .door_closed(door_closed),
        .timer_done (timer_done),
        .mag_on     (mag_on)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic exp);
        total++;
        assert (mag_on === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, mag_on, exp);
        end
    endtask

    initial begin
        clearn = 1'b0;
        startn = 1'b1;
        stopn = 1'b1;
        door_closed = 1'b1;
        timer_done = 1'b0;
        #1;
        check("reset_async", 1'b0);
        tick(3);
        check("reset_held", 1'b0);
        clearn = 1'b1;
        tick(5);
        check("idle_after_reset", 1'b0);

        // start latency = SYNC_STAGES + 2 = 4
        startn = 1'b0;
        tick(3);
        check("start_lat_minus1", 1'b0);
        tick(1);
        check("start_lat", 1'b1);
        startn = 1'b1;
        tick(4);
        check("cook_hold", 1'b1);

        // stop latency = SYNC_STAGES + 1 = 3
        stopn = 1'b0;
        tick(2);
        check("stop_lat_minus1", 1'b1);
        tick(1);
        check("stop_lat", 1'b0);
        startn = 1'b0;
        tick(6);
        check("start_during_stop", 1'b0);
        startn = 1'b1;
        tick(4);

        door_closed = 1'b0;
        tick(4);
        startn = 1'b0;
        tick(6);
        check("stop_door_start", 1'b0);
        startn = 1'b1;
        door_closed = 1'b1;
        tick(4);
        startn = 1'b0;
        tick(6);
        check("stop_only_start", 1'b0);
        startn = 1'b1;
        tick(4);

        stopn = 1'b1;
        tick(4);
        startn = 1'b0;
        tick(4);
        check("start_again", 1'b1);
        timer_done = 1'b1;
        tick(2);
        check("timer_lat_minus1", 1'b1);
        tick(1);
        check("timer_lat", 1'b0);
        tick(8);
        check("timer_start_held", 1'b0);
        timer_done = 1'b0;
        tick(6);
        check("timer_clear_no_edge", 1'b0);
        startn = 1'b1;
        tick(4);

        startn = 1'b0;
        tick(4);
        check("start_door_test", 1'b1);
        startn = 1'b1;
        tick(3);
        door_closed = 1'b0;
        tick(3);
        check("door_open_stop", 1'b0);
        door_closed = 1'b1;
        tick(6);
        check("door_close_no_edge", 1'b0);

        startn = 1'b0;
        tick(4);
        check("start_clear_test", 1'b1);
        #3;
        clearn = 1'b0;
        #1;
        check("clear_mid_cycle", 1'b0);
        #1;
        clearn = 1'b1;
        tick(8);
        check("held_low_after_clear", 1'b0);
        startn = 1'b1;
        tick(4);
        startn = 1'b0;
        tick(4);
        check("restart_after_clear", 1'b1);
        startn = 1'b1;
        tick(2);

        timer_done = 1'b1;
        tick(4);
        check("timer_stop_again", 1'b0);
        timer_done = 1'b0;
        tick(4);
        // start edge and stop arriving together: discarded, not queued
        startn = 1'b0;
        timer_done = 1'b1;
        tick(6);
        check("simul_start_stop", 1'b0);
        timer_done = 1'b0;
        tick(6);
        check("start_not_queued", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magnetron.md
MAGNETRON -- requirements
Module: magnetron

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each asynchronous input; legal range 2..4.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 clearn  input  1  asynchronous, active-low reset/clear.
REQ-004 startn  input  1  start pushbutton, active-low, asynchronous to clk.
REQ-005 stopn  input  1  stop pushbutton, active-low, asynchronous to clk.
REQ-006 door_closed  input  1  door interlock: 1 = closed, 0 = open; asynchronous to clk.
REQ-007 timer_done  input  1  cook timer expired, active-high; asynchronous to clk.
REQ-008 mag_on  output  1  magnetron enable, active-high, driven directly from a flop.
REQ-009 The block SHALL have one clock (clk) and one reset (clearn, asynchronous, active-low), fixed as decided.

Function
REQ-010 Each of startn, stopn, door_closed and timer_done SHALL pass through its own SYNC_STAGES-flop synchronizer before use.
REQ-011 Start event: falling edge of synchronized startn (previous 1, current 0), detected with one extra edge register.
REQ-012 Stop condition (level): synchronized stopn = 0, OR synchronized door_closed = 0, OR synchronized timer_done = 1.
REQ-013 Two-state FSM: IDLE (mag_on = 0) and COOK (mag_on = 1); mag_on SHALL be the registered decode of COOK.
REQ-014 IDLE -> COOK when a start event occurs AND no stop condition is present in the same cycle.
REQ-015 COOK -> IDLE on any cycle in which a stop condition is present.
REQ-016 Priority: clearn > stop condition > start event; simultaneous start and stop SHALL leave or force IDLE.
REQ-017 Holding startn low SHALL NOT re-enter COOK after a stop; a new falling edge of startn is required.
REQ-018 A start edge occurring while a stop condition is active SHALL be discarded, not queued.
REQ-019 Latency: input transition to mag_on change = SYNC_STAGES + 1 clk cycles for stop conditions; SYNC_STAGES + 2 for start (edge register).
REQ-020 Unreachable/illegal FSM encodings SHALL recover to IDLE on the next clock.
REQ-021 Stop condition held indefinitely SHALL keep mag_on = 0 regardless of startn activity.

Reset
REQ-022 clearn = 0 SHALL immediately (asynchronously) force FSM to IDLE and mag_on = 0.
REQ-023 During reset, synchronizer flops SHALL load their inactive values: startn/stopn chains = 1, door_closed chain = 0, timer_done chain = 0; edge register = 1.
REQ-024 On clearn release, no start event SHALL be generated unless startn actually falls after release.
REQ-025 Reset asserted mid-cook SHALL drop mag_on within the same time step, not waiting for clk.

Verification
REQ-026 Reset, then startn=1, stopn=1, door_closed=1, timer_done=0; drive startn 1->0 -> mag_on = 1 after SYNC_STAGES+2 cycles.
REQ-027 While cooking, stopn -> 0 -> mag_on = 0 after SYNC_STAGES+1 cycles; a new startn falling edge while stopn = 0 -> mag_on stays 0.
REQ-028 stopn = 0 held, door_closed -> 0, then startn 1->0 -> mag_on stays 0; door_closed -> 1 with stopn still 0, then startn 1->0 -> mag_on stays 0.
REQ-029 stopn = 1, door closed, start edge -> mag_on = 1; timer_done -> 1 -> mag_on = 0 after SYNC_STAGES+1 cycles; startn held low afterwards -> mag_on remains 0.
REQ-030 While cooking, door_closed -> 0 -> mag_on = 0; closing door again without a new start edge -> mag_on remains 0.
REQ-031 While cooking, pulse clearn low between clock edges -> mag_on = 0 immediately; after release with startn held low -> mag_on remains 0.
